// File: rtl/cache_data_slice_pkg.sv
// Shared types and helpers for the cache data slice.
// Fill sequencer states and the odd-parity generator.
package cache_slice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_e;

  localparam int PAR_MAX_W = 64;

  // odd parity bit: ^{d, odd_par(d)} == 1
  // callers zero-extend; zeros leave the xor unchanged
  function automatic logic odd_par(
    input logic [PAR_MAX_W-1:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/cache_data_slice_if.sv
// Bus bundle between address/way-select logic,
// the memory fill path and the data slice.
interface cache_data_slice_if #(
  parameter int DATA_W = 9,
  parameter int ADR_W  = 9,
  parameter int N_WAYS = 4,
  parameter int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
);

  logic [ADR_W-1:0]  cache_adr_h;
  logic [N_WAYS-1:0] way_sel_l;
  logic              cache_wr_l;
  logic [DATA_W-1:0] cpu_data_h;
  logic              fill_start_h;
  logic [WAY_W-1:0]  fill_way_h;
  logic              mem_valid_h;
  logic [DATA_W-1:0] mem_to_cache_h;
  logic              mem_par_h;
  logic              par_err_clr_h;
  logic [DATA_W-1:0] cache_data_h;
  logic              csh_par_bit_h;
  logic              rd_valid_h;
  logic              fill_busy_h;
  logic              fill_done_h;
  logic              par_err_h;

  modport master (
    output cache_adr_h,
    output way_sel_l,
    output cache_wr_l,
    output cpu_data_h,
    output fill_start_h,
    output fill_way_h,
    output mem_valid_h,
    output mem_to_cache_h,
    output mem_par_h,
    output par_err_clr_h,
    input  cache_data_h,
    input  csh_par_bit_h,
    input  rd_valid_h,
    input  fill_busy_h,
    input  fill_done_h,
    input  par_err_h
  );

  modport slave (
    input  cache_adr_h,
    input  way_sel_l,
    input  cache_wr_l,
    input  cpu_data_h,
    input  fill_start_h,
    input  fill_way_h,
    input  mem_valid_h,
    input  mem_to_cache_h,
    input  mem_par_h,
    input  par_err_clr_h,
    output cache_data_h,
    output csh_par_bit_h,
    output rd_valid_h,
    output fill_busy_h,
    output fill_done_h,
    output par_err_h
  );

endinterface

// File: rtl/cache_way_ram.sv
// One cache way: single write port, one synchronous read port.
// Read register is reset; array contents are not.
module cache_way_ram #(
  parameter int ADR_W  = 9,
  parameter int WORD_W = 10
) (
  input  logic              clk_h,
  input  logic              reset_l,
  input  logic              wr_en,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADR_W-1:0]  rd_adr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**ADR_W];

  // array write
  always_ff @(posedge clk_h) begin
    if (wr_en) mem[wr_adr] <= wr_data;
  end

  // read register; holds when not enabled, old data on same-cycle write
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_adr];
  end

endmodule

// File: rtl/cache_data_slice.sv
// Cache data slice: N ways of data+parity, registered read,
// sticky parity error and a one-way line-fill sequencer.
module cache_data_slice
  import cache_slice_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int ADR_W      = 9,
  parameter int N_WAYS     = 4,
  parameter int FILL_WORDS = 4
) (
  input logic               clk_h,
  input logic               reset_l,
  cache_data_slice_if.slave bus
);

  localparam int WAY_W  = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int CNT_W  = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;
  localparam int WORD_W = DATA_W + 1;
  localparam logic [ADR_W-1:0] LINE_MASK = ADR_W'(FILL_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FILL_WORDS - 1);

  fill_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADR_W-1:0]  base_q, base_d;
  logic [WAY_W-1:0]  fway_q, fway_d;
  logic              busy, done;

  logic              rd_req, cpu_wr, fill_we;
  logic [WAY_W-1:0]  rd_way, rd_way_q;
  logic              rd_valid_q, par_err_q;
  logic [ADR_W-1:0]  fill_adr, wr_adr;
  logic [WORD_W-1:0] wr_data, sel_word;
  logic [WORD_W-1:0] rd_word [N_WAYS];

  assign rd_req   = ~(&bus.way_sel_l) & bus.cache_wr_l;
  assign cpu_wr   = ~bus.cache_wr_l & ~busy;
  assign fill_we  = (state_q == FILL) & bus.mem_valid_h;
  assign fill_adr = base_q | ADR_W'(cnt_q);
  assign wr_adr   = fill_we ? fill_adr : bus.cache_adr_h;

  // fill word stores memory parity as delivered; cpu word gets fresh parity
  always_comb begin
    wr_data = {bus.cpu_data_h, odd_par(PAR_MAX_W'(bus.cpu_data_h))};
    if (fill_we) wr_data = {bus.mem_to_cache_h, bus.mem_par_h};
  end

  // lowest-index selected way wins the read
  always_comb begin
    rd_way = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (!bus.way_sel_l[i]) rd_way = WAY_W'(i);
    end
  end

  for (genvar w = 0; w < N_WAYS; w++) begin : g_way
    logic way_we, way_re;
    assign way_we = fill_we ? (fway_q == WAY_W'(w))
                            : (cpu_wr & ~bus.way_sel_l[w]);
    assign way_re = rd_req & (rd_way == WAY_W'(w));
    cache_way_ram #(
      .ADR_W  (ADR_W),
      .WORD_W (WORD_W)
    ) u_ram (
      .clk_h   (clk_h),
      .reset_l (reset_l),
      .wr_en   (way_we),
      .wr_adr  (wr_adr),
      .wr_data (wr_data),
      .rd_en   (way_re),
      .rd_adr  (bus.cache_adr_h),
      .rd_data (rd_word[w])
    );
  end

  // read way and valid; way holds so outputs keep last word
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      rd_way_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_way_q <= rd_way;
    end
  end

  assign sel_word = rd_word[rd_way_q];

  // sticky parity error; set beats clear
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) par_err_q <= 1'b0;
    else if (rd_valid_q && !(^sel_word)) par_err_q <= 1'b1;
    else if (bus.par_err_clr_h) par_err_q <= 1'b0;
  end

  // fill sequencer state register
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      fway_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      fway_q  <= fway_d;
    end
  end

  // fill sequencer next state and status outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    fway_d  = fway_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.fill_start_h) begin
          state_d = FILL;
          base_d  = bus.cache_adr_h & ~LINE_MASK;
          fway_d  = bus.fill_way_h;
          cnt_d   = '0;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (bus.mem_valid_h) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cache_data_h  = sel_word[WORD_W-1:1];
  assign bus.csh_par_bit_h = sel_word[0];
  assign bus.rd_valid_h    = rd_valid_q;
  assign bus.par_err_h     = par_err_q;
  assign bus.fill_busy_h   = busy;
  assign bus.fill_done_h   = done;

endmodule
